// File: rtl/clk_gate_ctrl_if.sv
// ============================================================================
// Module : clk_gate_ctrl_if
// Brief  : Activity, wake handshake and gate-enable signals of clk_gate_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface clk_gate_ctrl_if #(
  parameter int CNT_WIDTH = 16
) ();
  logic                 busy_i;
  logic                 force_on_i;
  logic                 wake_req_i;
  logic                 wake_ack_o;
  logic                 gate_en_o;
  logic                 clk_active_o;
  logic [CNT_WIDTH-1:0] off_events_o;

  modport master (
    output busy_i, force_on_i, wake_req_i,
    input  wake_ack_o, gate_en_o, clk_active_o, off_events_o
  );

  modport slave (
    input  busy_i, force_on_i, wake_req_i,
    output wake_ack_o, gate_en_o, clk_active_o, off_events_o
  );
endinterface

`default_nettype wire

// File: rtl/clk_gate_ctrl.sv
// ============================================================================
// Module : clk_gate_ctrl
// Brief  : Idle-detecting clock-gate enable controller with wake handshake.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_gate_ctrl #(
  parameter int IDLE_CYCLES  = 16,
  parameter int WAKE_LATENCY = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  clk_gate_ctrl_if.slave gate
);

  localparam int MAX_LAT = (IDLE_CYCLES > WAKE_LATENCY) ? IDLE_CYCLES : WAKE_LATENCY;
  localparam int CW      = $clog2(MAX_LAT) + 1;

  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_LATENCY - 1);

  localparam logic [1:0] ST_ON     = 2'd0;
  localparam logic [1:0] ST_OFF    = 2'd1;
  localparam logic [1:0] ST_WAKING = 2'd2;

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nxt;
  logic                 demand;
  logic                 gate_en;
  logic                 clk_active;
  logic                 wake_ack;
  logic [CNT_WIDTH-1:0] off_events;

  assign demand = gate.busy_i | gate.force_on_i | gate.wake_req_i;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_ON: begin
        if (demand) begin
          cnt_nxt = '0;
        end else if (cnt == IDLE_LAST) begin
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_OFF: begin
        if (demand) begin
          state_nxt = ST_WAKING;
          cnt_nxt   = '0;
        end
      end
      ST_WAKING: begin
        // Once started, a wake always completes so the gate cell sees a clean enable.
        if (cnt == WAKE_LAST) begin
          state_nxt = ST_ON;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_ON;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= ST_ON;
      cnt        <= '0;
      gate_en    <= 1'b1;
      clk_active <= 1'b1;
      wake_ack   <= 1'b0;
      off_events <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      gate_en    <= (state_nxt != ST_OFF);
      clk_active <= (state_nxt == ST_ON);
      wake_ack   <= (state_nxt == ST_ON) & gate.wake_req_i;
      if ((state == ST_ON) && (state_nxt == ST_OFF) && (off_events != '1)) begin
        off_events <= off_events + 1'b1;
      end
    end
  end

  assign gate.gate_en_o    = gate_en;
  assign gate.clk_active_o = clk_active;
  assign gate.wake_ack_o   = wake_ack;
  assign gate.off_events_o = off_events;

endmodule

`default_nettype wire

// File: tb/tb_clk_gate_ctrl.sv
// ============================================================================
// Module : tb_clk_gate_ctrl
// Brief  : Vector table, corner sequences and randomized model check.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_clk_gate_ctrl;

  localparam int IDLE_A = 4;
  localparam int WAKE_A = 2;
  localparam int CW_A   = 16;
  localparam int CW_B   = 2;

  typedef struct {
    logic        rst_n;
    logic        busy;
    logic        force_on;
    logic        wake_req;
    logic        gate_en;
    logic        clk_active;
    logic        wake_ack;
    logic [15:0] off_events;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  clk_gate_ctrl_if #(.CNT_WIDTH(CW_A)) ifa ();
  clk_gate_ctrl_if #(.CNT_WIDTH(CW_B)) ifb ();

  clk_gate_ctrl #(.IDLE_CYCLES(IDLE_A), .WAKE_LATENCY(WAKE_A), .CNT_WIDTH(CW_A)) dut_a (
    .clk_i(clk), .rst_ni(rst_a), .gate(ifa)
  );

  clk_gate_ctrl #(.IDLE_CYCLES(1), .WAKE_LATENCY(2), .CNT_WIDTH(CW_B)) dut_b (
    .clk_i(clk), .rst_ni(rst_b), .gate(ifb)
  );

  always #5 clk = ~clk;

  // Reference: the gated domain is either running, waking with a countdown,
  // or off; events count gate-offs from running, clipped at the counter max.
  bit m_off;
  int m_wake_left;
  int m_streak;
  int m_ev;
  bit m_ack;

  task automatic model_step(input logic r, input logic b, input logic f, input logic w);
    bit d;
    d = b | f | w;
    if (!r) begin
      m_off = 0; m_wake_left = 0; m_streak = 0; m_ev = 0; m_ack = 0;
    end else begin
      if (m_wake_left > 0) begin
        m_wake_left--;
        m_streak = 0;
      end else if (m_off) begin
        if (d) begin
          m_off       = 0;
          m_wake_left = WAKE_A;
        end
      end else begin
        m_streak = d ? 0 : m_streak + 1;
        if (m_streak == IDLE_A) begin
          m_off    = 1;
          m_streak = 0;
          if (m_ev < (1 << CW_A) - 1) m_ev++;
        end
      end
      m_ack = !m_off && (m_wake_left == 0) && w;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic b, input logic f, input logic w,
                     input logic g, input logic a, input logic k, input logic [15:0] e);
    vec_t v;
    v.rst_n = r; v.busy = b; v.force_on = f; v.wake_req = w;
    v.gate_en = g; v.clk_active = a; v.wake_ack = k; v.off_events = e;
    vecs.push_back(v);
  endtask

  task automatic drive_a(input logic r, input logic b, input logic f, input logic w);
    rst_a = r; ifa.busy_i = b; ifa.force_on_i = f; ifa.wake_req_i = w;
  endtask

  task automatic drive_b(input logic r, input logic b);
    rst_b = r; ifb.busy_i = b; ifb.force_on_i = 1'b0; ifb.wake_req_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive_a(1'b0, 1'b0, 1'b0, 1'b0);
    drive_b(1'b0, 1'b0);

    //  rst busy force req | gate act ack ev
    add(0, 0, 0, 0,  1, 1, 0, 0);
    add(1, 0, 0, 0,  1, 1, 0, 0);
    add(1, 0, 0, 0,  1, 1, 0, 0);
    add(1, 0, 0, 0,  1, 1, 0, 0);
    add(1, 0, 0, 0,  0, 0, 0, 1);
    add(1, 0, 0, 0,  0, 0, 0, 1);
    add(1, 0, 0, 1,  1, 0, 0, 1);
    add(1, 0, 0, 1,  1, 0, 0, 1);
    add(1, 0, 0, 1,  1, 1, 1, 1);
    add(1, 0, 0, 0,  1, 1, 0, 1);
    add(1, 0, 0, 0,  1, 1, 0, 1);
    add(1, 0, 0, 0,  1, 1, 0, 1);
    add(1, 0, 0, 0,  0, 0, 0, 2);
    add(1, 1, 0, 0,  1, 0, 0, 2);
    add(1, 0, 0, 0,  1, 0, 0, 2);
    add(1, 0, 0, 0,  1, 1, 0, 2);
    add(1, 0, 0, 0,  1, 1, 0, 2);
    add(1, 0, 0, 0,  1, 1, 0, 2);
    add(1, 1, 0, 0,  1, 1, 0, 2);
    add(1, 0, 0, 0,  1, 1, 0, 2);
    add(1, 0, 0, 0,  1, 1, 0, 2);
    add(1, 0, 0, 0,  1, 1, 0, 2);
    add(1, 0, 0, 0,  0, 0, 0, 3);
    add(1, 0, 1, 0,  1, 0, 0, 3);
    add(0, 0, 0, 0,  1, 1, 0, 0);
    add(1, 0, 0, 0,  1, 1, 0, 0);
    add(1, 0, 0, 0,  1, 1, 0, 0);
    add(1, 0, 0, 0,  1, 1, 0, 0);
    add(1, 0, 0, 0,  0, 0, 0, 1);
    add(1, 1, 0, 0,  1, 0, 0, 1);
    add(1, 0, 0, 0,  1, 0, 0, 1);
    add(1, 0, 0, 0,  1, 1, 0, 1);
    add(1, 0, 0, 0,  1, 1, 0, 1);
    add(1, 0, 0, 0,  1, 1, 0, 1);
    add(1, 0, 0, 0,  1, 1, 0, 1);
    add(0, 0, 0, 0,  1, 1, 0, 0);
    add(1, 0, 0, 0,  1, 1, 0, 0);
    add(1, 0, 0, 0,  1, 1, 0, 0);
    add(1, 0, 0, 0,  1, 1, 0, 0);
    add(1, 0, 0, 0,  0, 0, 0, 1);

    #2;
    foreach (vecs[i]) begin
      drive_a(vecs[i].rst_n, vecs[i].busy, vecs[i].force_on, vecs[i].wake_req);
      tick();
      check($sformatf("vec%0d.gate_en", i),    32'(ifa.gate_en_o),    32'(vecs[i].gate_en));
      check($sformatf("vec%0d.clk_active", i), 32'(ifa.clk_active_o), 32'(vecs[i].clk_active));
      check($sformatf("vec%0d.wake_ack", i),   32'(ifa.wake_ack_o),   32'(vecs[i].wake_ack));
      check($sformatf("vec%0d.off_events", i), 32'(ifa.off_events_o), 32'(vecs[i].off_events));
    end

    // Force-on from OFF: WAKING for two edges, then held on for 100 edges.
    drive_a(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check("force_wake1.gate_en", 32'(ifa.gate_en_o), 32'd1);
    check("force_wake1.clk_active", 32'(ifa.clk_active_o), 32'd0);
    tick();
    check("force_wake2.clk_active", 32'(ifa.clk_active_o), 32'd0);
    tick();
    check("force_on.clk_active", 32'(ifa.clk_active_o), 32'd1);
    for (int i = 0; i < 100; i++) begin
      tick();
      check("force_hold.gate_en", 32'(ifa.gate_en_o), 32'd1);
      check("force_hold.off_events", 32'(ifa.off_events_o), 32'd1);
    end

    // Saturating event counter on a 2-bit instance with single-cycle idle timeout.
    tick();
    drive_b(1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      drive_b(1'b1, 1'b0);
      tick();
      check("sat.gate_off", 32'(ifb.gate_en_o), 32'd0);
      check("sat.off_events", 32'(ifb.off_events_o), (k < 3) ? k : 3);
      drive_b(1'b1, 1'b1);
      tick();
      drive_b(1'b1, 1'b0);
      tick();
      tick();
      check("sat.clk_active", 32'(ifb.clk_active_o), 32'd1);
    end

    // Randomized traffic against the reference model.
    drive_a(1'b0, 1'b0, 1'b0, 1'b0);
    model_step(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3000; i++) begin
      logic r, b, f, w;
      r = ($urandom_range(0, 63) != 0);
      b = ($urandom_range(0, 9) == 0);
      f = ($urandom_range(0, 19) == 0);
      w = ($urandom_range(0, 11) == 0);
      drive_a(r, b, f, w);
      model_step(r, b, f, w);
      tick();
      check("rnd.gate_en",    32'(ifa.gate_en_o),    32'(!m_off));
      check("rnd.clk_active", 32'(ifa.clk_active_o), 32'(!m_off && m_wake_left == 0));
      check("rnd.wake_ack",   32'(ifa.wake_ack_o),   32'(m_ack));
      check("rnd.off_events", 32'(ifa.off_events_o), 32'(m_ev));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
